writeback_cdb: RTL

Completion-stage block directly upstream of the physical register file. It collects results from NUM_FU functional units through valid/ready handshakes and buffers one result per FU. Each cycle it grants up to `N results round-robin and drives them, registered, onto the `N register-file write ports and the matching CDB broadcast lanes, which wake up the RS and complete the ROB.

---
 rtl/writeback_cdb_pkg.sv | 25 ++
 rtl/writeback_cdb_if.sv | 37 +++
 rtl/writeback_cdb_rr_select.sv | 42 ++++
 rtl/writeback_cdb.sv | 127 ++++++++++++
 4 files changed

// File: rtl/writeback_cdb_pkg.sv
// Shared definitions for the writeback / CDB stage: lane and FU counts,
// physical tag, data and ROB index types, and the packet carried by slots and lanes.
package writeback_cdb_pkg;

    localparam int unsigned WB_N             = 2;   // writeback / CDB lanes
    localparam int unsigned WB_NUM_FU        = 4;   // producing functional units
    localparam int unsigned PHYS_REG_SZ_R10K = 64;  // physical register file entries
    localparam int unsigned ROB_SZ           = 32;  // reorder buffer entries

    typedef logic [$clog2(PHYS_REG_SZ_R10K)-1:0] PHYS_TAG;
    typedef logic [31:0]                         DATA;
    typedef logic [$clog2(ROB_SZ)-1:0]           ROB_IDX;

    typedef struct packed {
        PHYS_TAG tag;
        DATA     data;
        ROB_IDX  rob;
    } CDB_PACKET;

    // Physical tag 0 is the hardwired zero register and is never written
    function automatic logic tag_writes(input PHYS_TAG tag);
        return tag != '0;
    endfunction

endpackage

// File: rtl/writeback_cdb_if.sv
// FU-side result handshake and the regfile-write / CDB broadcast lanes.
// master: the FUs and result consumers; slave: the writeback_cdb block.
interface writeback_cdb_if
    import writeback_cdb_pkg::*;
#(
    parameter int unsigned N      = WB_N,
    parameter int unsigned NUM_FU = WB_NUM_FU
) ();

    logic    [NUM_FU-1:0] fu_valid;
    logic    [NUM_FU-1:0] fu_ready;
    PHYS_TAG [NUM_FU-1:0] fu_tag;
    DATA     [NUM_FU-1:0] fu_data;
    ROB_IDX  [NUM_FU-1:0] fu_rob;

    logic    [N-1:0]      write_en;
    PHYS_TAG [N-1:0]      write_tags;
    DATA     [N-1:0]      write_data;
    logic    [N-1:0]      cdb_valid;
    PHYS_TAG [N-1:0]      cdb_tag;
    ROB_IDX  [N-1:0]      cdb_rob;

    modport master (
        output fu_valid, fu_tag, fu_data, fu_rob,
        input  fu_ready,
        input  write_en, write_tags, write_data,
        input  cdb_valid, cdb_tag, cdb_rob
    );

    modport slave (
        input  fu_valid, fu_tag, fu_data, fu_rob,
        output fu_ready,
        output write_en, write_tags, write_data,
        output cdb_valid, cdb_tag, cdb_rob
    );

endinterface

// File: rtl/writeback_cdb_rr_select.sv
// Round-robin lane selector: starting at the pointer, the first N valid slots
// are granted, the k-th one onto lane k. Purely combinational.
module wb_rr_select
    import writeback_cdb_pkg::*;
#(
    parameter  int unsigned N      = WB_N,
    parameter  int unsigned NUM_FU = WB_NUM_FU,
    localparam int unsigned PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic [NUM_FU-1:0]        valid,
    input  logic [PTR_W-1:0]         start,
    output logic [N-1:0][NUM_FU-1:0] grant_oh,
    output logic [NUM_FU-1:0]        granted,
    output logic [PTR_W-1:0]         next_ptr
);

    // Scan slots in circular order from start, filling lanes 0..N-1 without gaps;
    // the pointer moves just past the last slot that was granted
    always_comb begin
        int unsigned      lane;
        logic [PTR_W-1:0] idx;
        grant_oh = '0;
        granted  = '0;
        next_ptr = start;
        lane     = 0;
        idx      = '0;
        for (int unsigned off = 0; off < NUM_FU; off++) begin
            idx = PTR_W'((32'(start) + off) % NUM_FU);
            if (valid[idx] && (lane < N)) begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (k == lane) begin
                        grant_oh[k][idx] = 1'b1;
                    end
                end
                granted[idx] = 1'b1;
                next_ptr     = PTR_W'((32'(idx) + 1) % NUM_FU);
                lane         = lane + 1;
            end
        end
    end

endmodule

// File: rtl/writeback_cdb.sv
// Writeback / CDB stage: one holding slot per FU, round-robin grant of up to
// N results per cycle, registered onto regfile write ports and CDB lanes.
module writeback_cdb
    import writeback_cdb_pkg::*;
#(
    parameter  int unsigned N      = WB_N,
    parameter  int unsigned NUM_FU = WB_NUM_FU,
    localparam int unsigned PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    writeback_cdb_if.slave wb
);

    logic      [NUM_FU-1:0]        slot_valid;
    CDB_PACKET                     slot_pkt [NUM_FU];
    logic      [PTR_W-1:0]         rr_ptr;

    logic      [N-1:0][NUM_FU-1:0] grant_oh;
    logic      [NUM_FU-1:0]        granted;
    logic      [PTR_W-1:0]         next_ptr;
    logic      [NUM_FU-1:0]        accept;

    logic      [N-1:0]             lane_vld_next;
    CDB_PACKET                     lane_next [N];

    logic      [N-1:0]             lane_valid;
    logic      [N-1:0]             lane_we;
    CDB_PACKET                     lane_pkt [N];

    wb_rr_select #(
        .N      (N),
        .NUM_FU (NUM_FU)
    ) u_select (
        .valid    (slot_valid),
        .start    (rr_ptr),
        .grant_oh (grant_oh),
        .granted  (granted),
        .next_ptr (next_ptr)
    );

    // A slot can take a new result when empty or being drained this cycle
    assign wb.fu_ready = {NUM_FU{~flush}} & (~slot_valid | granted);
    assign accept      = wb.fu_valid & wb.fu_ready;

    // Holding slots: refill wins over drain so a granted slot can reload in the same cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid <= '0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                slot_pkt[i] <= '0;
            end
        end else if (flush) begin
            slot_valid <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (accept[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_pkt[i]   <= '{tag: wb.fu_tag[i], data: wb.fu_data[i], rob: wb.fu_rob[i]};
                end else if (granted[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer follows the last granted slot; flush restarts it at slot 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else if (|granted) begin
            rr_ptr <= next_ptr;
        end
    end

    // Route each lane's one-hot grant to its slot packet; ungranted lanes carry zeros
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            lane_vld_next[k] = |grant_oh[k];
            lane_next[k]     = '0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (grant_oh[k][i]) begin
                    lane_next[k] = slot_pkt[i];
                end
            end
        end
    end

    // Lane output registers; the zero register still broadcasts but never writes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lane_valid <= '0;
            lane_we    <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                lane_pkt[k] <= '0;
            end
        end else if (flush) begin
            lane_valid <= '0;
            lane_we    <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                lane_pkt[k] <= '0;
            end
        end else begin
            lane_valid <= lane_vld_next;
            for (int unsigned k = 0; k < N; k++) begin
                lane_we[k]  <= lane_vld_next[k] & tag_writes(lane_next[k].tag);
                lane_pkt[k] <= lane_next[k];
            end
        end
    end

    // Fan the lane registers out to the regfile write ports and the CDB
    always_comb begin
        wb.write_en  = lane_we;
        wb.cdb_valid = lane_valid;
        for (int unsigned k = 0; k < N; k++) begin
            wb.write_tags[k] = lane_pkt[k].tag;
            wb.write_data[k] = lane_pkt[k].data;
            wb.cdb_tag[k]    = lane_pkt[k].tag;
            wb.cdb_rob[k]    = lane_pkt[k].rob;
        end
    end

endmodule
